// File: rtl/seq_divider_ctl.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock,
// with start/busy/done handshake, signed mode, overflow and divide-by-zero detection.
module seq_divider_ctl #(
   parameter int N = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [2*N-1:0]   dividend,
   input  logic [N-1:0]     divisor,
   output logic             busy,
   output logic             done,
   output logic [N-1:0]     quotient,
   output logic [N-1:0]     remainder,
   output logic             ov,
   output logic             divbyzero
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST    = CW'(N - 1);
   localparam logic [N-1:0]  MAX_POS     = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]  MIN_NEG_MAG = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   function automatic logic [2*N-1:0] neg_wide(input logic [2*N-1:0] x, input logic neg);
      return neg ? ({(2*N){1'b0}} - x) : x;
   endfunction

   function automatic logic [N-1:0] neg_narrow(input logic [N-1:0] x, input logic neg);
      return neg ? ({N{1'b0}} - x) : x;
   endfunction

   state_t           state_r, state_nxt;
   // Work register upper bit of W is always 0 between steps, so only 2N bits are stored.
   logic [2*N-1:0]   w_r, w_nxt;
   logic [N-1:0]     dm_r, dm_nxt;
   logic             sd_r, sd_nxt, sv_r, sv_nxt, sm_r, sm_nxt;
   logic [CW-1:0]    cnt_r, cnt_nxt;
   logic [N-1:0]     q_r, q_nxt, r_r, r_nxt;
   logic             ov_r, ov_nxt, dbz_r, dbz_nxt;
   logic             busy_r, done_r;

   logic             sd_in_s, sv_in_s;
   logic [2*N-1:0]   dvd_mag_s;
   logic [N-1:0]     dvs_mag_s;
   logic [2*N:0]     w_sh_s;
   logic             nonneg_s;
   logic [N-1:0]     diff_s;
   logic [2*N-1:0]   w_step_s;
   logic [N-1:0]     qm_s, rm_s;
   logic             sov_s;

   assign busy      = busy_r;
   assign done      = done_r;
   assign quotient  = q_r;
   assign remainder = r_r;
   assign ov        = ov_r;
   assign divbyzero = dbz_r;

   // Next-state, datapath step and result formatting.
   always_comb begin
      state_nxt = state_r;
      w_nxt     = w_r;
      dm_nxt    = dm_r;
      sd_nxt    = sd_r;
      sv_nxt    = sv_r;
      sm_nxt    = sm_r;
      cnt_nxt   = cnt_r;
      q_nxt     = q_r;
      r_nxt     = r_r;
      ov_nxt    = ov_r;
      dbz_nxt   = dbz_r;

      sd_in_s   = dividend[2*N-1] & signed_mode;
      sv_in_s   = divisor[N-1] & signed_mode;
      dvd_mag_s = neg_wide(dividend, sd_in_s);
      dvs_mag_s = neg_narrow(divisor, sv_in_s);

      w_sh_s    = {w_r, 1'b0};
      nonneg_s  = (w_sh_s[2*N:N] >= {1'b0, dm_r});
      // True difference is below Dm, so the N-bit modular result is exact.
      diff_s    = w_sh_s[2*N-1:N] - dm_r;
      if (nonneg_s) begin
         w_step_s = {diff_s, w_sh_s[N-1:1], 1'b1};
      end else begin
         w_step_s = w_sh_s[2*N-1:0];
      end
      qm_s      = w_step_s[N-1:0];
      rm_s      = w_step_s[2*N-1:N];
      sov_s     = (sd_r == sv_r) ? (qm_s > MAX_POS) : (qm_s > MIN_NEG_MAG);

      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               sm_nxt  = signed_mode;
               sd_nxt  = sd_in_s;
               sv_nxt  = sv_in_s;
               w_nxt   = dvd_mag_s;
               dm_nxt  = dvs_mag_s;
               cnt_nxt = {CW{1'b0}};
               q_nxt   = {N{1'b0}};
               r_nxt   = {N{1'b0}};
               ov_nxt  = 1'b0;
               dbz_nxt = 1'b0;
               if (divisor == {N{1'b0}}) begin
                  dbz_nxt   = 1'b1;
                  state_nxt = ST_DONE;
               end else if (dvd_mag_s[2*N-1:N] >= dvs_mag_s) begin
                  ov_nxt    = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_RUN;
               end
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            w_nxt = w_step_s;
            if (cnt_r == CNT_LAST) begin
               state_nxt = ST_DONE;
               if (sm_r && sov_s) begin
                  ov_nxt = 1'b1;
                  q_nxt  = {N{1'b0}};
                  r_nxt  = {N{1'b0}};
               end else if (sm_r) begin
                  q_nxt  = neg_narrow(qm_s, sd_r ^ sv_r);
                  r_nxt  = neg_narrow(rm_s, sd_r);
               end else begin
                  q_nxt  = qm_s;
                  r_nxt  = rm_s;
               end
            end else begin
               cnt_nxt = cnt_r + CW'(1'b1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Datapath, result and handshake registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_r    <= {(2*N){1'b0}};
         dm_r   <= {N{1'b0}};
         sd_r   <= 1'b0;
         sv_r   <= 1'b0;
         sm_r   <= 1'b0;
         cnt_r  <= {CW{1'b0}};
         q_r    <= {N{1'b0}};
         r_r    <= {N{1'b0}};
         ov_r   <= 1'b0;
         dbz_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         w_r    <= w_nxt;
         dm_r   <= dm_nxt;
         sd_r   <= sd_nxt;
         sv_r   <= sv_nxt;
         sm_r   <= sm_nxt;
         cnt_r  <= cnt_nxt;
         q_r    <= q_nxt;
         r_r    <= r_nxt;
         ov_r   <= ov_nxt;
         dbz_r  <= dbz_nxt;
         busy_r <= (state_nxt == ST_RUN);
         done_r <= (state_nxt == ST_DONE);
      end
   end

endmodule

// File: tb/tb_seq_divider_ctl.sv
// Self-checking bench for seq_divider_ctl (N=5): directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_seq_divider_ctl;

   localparam int N = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          signed_mode = 1'b0;
   logic [9:0]    dividend = 10'd0;
   logic [4:0]    divisor = 5'd0;
   logic          busy, done, ov, divbyzero;
   logic [4:0]    quotient, remainder;

   int checks = 0;
   int errors = 0;

   seq_divider_ctl #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .ov(ov), .divbyzero(divbyzero)
   );

   always #5 clk = ~clk;

   // Reference: plain integer division, truncating toward zero in signed mode.
   task automatic ref_div(input logic sm, input logic [9:0] a, input logic [4:0] b,
                          output logic [4:0] q, output logic [4:0] r,
                          output logic eov, output logic edbz, output int lat);
      int x, y, ax, ay, qq, rr;
      q = 5'd0; r = 5'd0; eov = 1'b0; edbz = 1'b0; lat = N + 1;
      x = sm ? int'($signed(a)) : int'(a);
      y = sm ? int'($signed(b)) : int'(b);
      if (y == 0) begin
         edbz = 1'b1; lat = 1;
      end else begin
         ax = (x < 0) ? -x : x;
         ay = (y < 0) ? -y : y;
         qq = x / y;
         rr = x % y;
         if (ax / ay >= 32) begin
            eov = 1'b1; lat = 1;
         end else if (sm && (qq > 15 || qq < -16)) begin
            eov = 1'b1;
         end else begin
            q = qq[4:0]; r = rr[4:0];
         end
      end
   endtask

   // Present one request in cycle 0, then scramble the operands; returns at cycle 1.
   task automatic start_op(input logic sm, input logic [9:0] a, input logic [4:0] b);
      @(negedge clk);
      start = 1'b1; signed_mode = sm; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0; signed_mode = 1'($urandom); dividend = 10'($urandom); divisor = 5'($urandom);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if ({busy, done, ov, divbyzero, quotient, remainder} !== 14'd0)
         begin errors++; $display("FAIL reset_outputs got %b expected 0", {busy, done, ov, divbyzero, quotient, remainder}); end
      rst = 1'b0;
   endtask

   task automatic test_unsigned_basic;
      start_op(1'b0, 10'd100, 5'd7);
      for (int c = 1; c <= 5; c++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL basic_busy cycle %0d got busy=%b done=%b expected busy=1 done=0", c, busy, done); end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0)
         begin errors++; $display("FAIL basic_done got done=%b busy=%b expected done=1 busy=0", done, busy); end
      checks++;
      if (quotient !== 5'd14 || remainder !== 5'd2)
         begin errors++; $display("FAIL basic_result got q=%0d r=%0d expected q=14 r=2", quotient, remainder); end
      checks++;
      if (ov !== 1'b0 || divbyzero !== 1'b0)
         begin errors++; $display("FAIL basic_flags got ov=%b dbz=%b expected 0 0", ov, divbyzero); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || quotient !== 5'd14)
         begin errors++; $display("FAIL basic_pulse got done=%b q=%0d expected done=0 q=14", done, quotient); end
   endtask

   task automatic test_errors;
      logic [9:0] av[3] = '{10'd37, 10'd400, 10'd224};
      logic [4:0] bv[3] = '{5'd0, 5'd7, 5'd7};
      for (int i = 0; i < 3; i++) begin
         start_op(1'b0, av[i], bv[i]);
         checks++;
         if (done !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL err%0d_latency got done=%b busy=%b expected done=1 busy=0", i, done, busy); end
         checks++;
         if (divbyzero !== (i == 0) || ov !== (i != 0))
            begin errors++; $display("FAIL err%0d_flags got dbz=%b ov=%b expected dbz=%b ov=%b", i, divbyzero, ov, i == 0, i != 0); end
         checks++;
         if (quotient !== 5'd0 || remainder !== 5'd0)
            begin errors++; $display("FAIL err%0d_result got q=%0d r=%0d expected 0 0", i, quotient, remainder); end
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL err%0d_idle got busy=%b done=%b expected 0 0", i, busy, done); end
      end
   endtask

   task automatic test_signed;
      // -100/7, 112/7, -112/7
      logic [9:0] av[3] = '{10'd924, 10'd112, 10'd912};
      logic [4:0] eq[3] = '{5'b10010, 5'd0, 5'b10000};
      logic [4:0] er[3] = '{5'b11110, 5'd0, 5'd0};
      logic       eo[3] = '{1'b0, 1'b1, 1'b0};
      int cyc;
      for (int i = 0; i < 3; i++) begin
         start_op(1'b1, av[i], 5'd7);
         wait_done(cyc);
         checks++;
         if (cyc != 6)
            begin errors++; $display("FAIL signed%0d_latency got %0d expected 6", i, cyc); end
         checks++;
         if (quotient !== eq[i] || remainder !== er[i])
            begin errors++; $display("FAIL signed%0d_result got q=%b r=%b expected q=%b r=%b", i, quotient, remainder, eq[i], er[i]); end
         checks++;
         if (ov !== eo[i] || divbyzero !== 1'b0)
            begin errors++; $display("FAIL signed%0d_flags got ov=%b dbz=%b expected ov=%b dbz=0", i, ov, divbyzero, eo[i]); end
      end
   endtask

   task automatic test_random;
      logic [9:0] a;
      logic [4:0] b, eq, er;
      logic       sm, eov, edbz;
      int lat, cyc, v;
      for (int i = 0; i < 80; i++) begin
         sm = 1'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            a = 10'($urandom);
         end else begin
            v = $urandom_range(0, 400) - 200;
            a = v[9:0];
         end
         b = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
         ref_div(sm, a, b, eq, er, eov, edbz, lat);
         start_op(sm, a, b);
         wait_done(cyc);
         checks++;
         if (cyc != lat)
            begin errors++; $display("FAIL rand%0d_latency sm=%b %0d/%0d got %0d expected %0d", i, sm, a, b, cyc, lat); end
         checks++;
         if (quotient !== eq || remainder !== er)
            begin errors++; $display("FAIL rand%0d_result sm=%b %0d/%0d got q=%b r=%b expected q=%b r=%b", i, sm, a, b, quotient, remainder, eq, er); end
         checks++;
         if (ov !== eov || divbyzero !== edbz)
            begin errors++; $display("FAIL rand%0d_flags sm=%b %0d/%0d got ov=%b dbz=%b expected ov=%b dbz=%b", i, sm, a, b, ov, divbyzero, eov, edbz); end
      end
   endtask

   task automatic test_start_ignored;
      int cyc;
      start_op(1'b0, 10'd100, 5'd7);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b1; dividend = 10'd50; divisor = 5'd3;
      @(negedge clk);
      start = 1'b0;
      cyc = 4;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != 6)
         begin errors++; $display("FAIL ignored_latency got %0d expected 6", cyc); end
      checks++;
      if (quotient !== 5'd14 || remainder !== 5'd2)
         begin errors++; $display("FAIL ignored_result got q=%0d r=%0d expected q=14 r=2", quotient, remainder); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL ignored_no_queue got busy=%b done=%b expected 0 0", busy, done); end
   endtask

   task automatic test_back_to_back;
      int cyc;
      start_op(1'b0, 10'd100, 5'd7);
      wait_done(cyc);
      checks++;
      if (cyc != 6 || quotient !== 5'd14 || remainder !== 5'd2)
         begin errors++; $display("FAIL b2b_first got cyc=%0d q=%0d r=%0d expected 6 14 2", cyc, quotient, remainder); end
      start = 1'b1; signed_mode = 1'b0; dividend = 10'd90; divisor = 5'd7;
      @(negedge clk);
      start = 1'b0; dividend = 10'd5; divisor = 5'd1;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0)
         begin errors++; $display("FAIL b2b_accept got busy=%b done=%b expected busy=1 done=0", busy, done); end
      wait_done(cyc);
      checks++;
      if (cyc != 6)
         begin errors++; $display("FAIL b2b_latency got %0d expected 6", cyc); end
      checks++;
      if (quotient !== 5'd12 || remainder !== 5'd6)
         begin errors++; $display("FAIL b2b_result got q=%0d r=%0d expected q=12 r=6", quotient, remainder); end
   endtask

   task automatic test_reset_midrun;
      int cyc;
      bit saw_done;
      start_op(1'b0, 10'd100, 5'd7);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, ov, divbyzero, quotient, remainder} !== 14'd0)
         begin errors++; $display("FAIL midrun_reset got %b expected 0", {busy, done, ov, divbyzero, quotient, remainder}); end
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done)
         begin errors++; $display("FAIL midrun_abort got activity=1 expected 0"); end
      start_op(1'b0, 10'd100, 5'd7);
      wait_done(cyc);
      checks++;
      if (cyc != 6 || quotient !== 5'd14 || remainder !== 5'd2)
         begin errors++; $display("FAIL midrun_fresh got cyc=%0d q=%0d r=%0d expected 6 14 2", cyc, quotient, remainder); end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_errors();
      test_signed();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
